// File: rtl/pixel_array_readout_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pixel_array_readout_ctrl
// Description : NROWS x NCOLS pixel-array frame controller. Sequences
//               ERASE, EXPOSE, CONVERT (ramp enable plus a counter driven
//               onto the shared DATA bus) and then a per-pixel READ. Each
//               pixel value is captured from the bus and streamed out over
//               a valid/ready port.
//               Optional build macro CONTINUOUS_FRAMES_EN: when defined,
//               start held high in DONE launches the next frame directly.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_array_readout_ctrl #(
    parameter  int NROWS        = 2,
    parameter  int NCOLS        = 2,
    parameter  int DW           = 8,
    parameter  int ERASE_CYCLES = 5,
    parameter  int EXP_W        = 8,
    parameter  int READ_SETTLE  = 2,
    localparam int c_NPIX       = NROWS * NCOLS,
    localparam int c_IDX_W      = (c_NPIX > 1) ? $clog2(c_NPIX) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [EXP_W-1:0]  expose_time,
    output logic              erase,
    output logic              expose,
    output logic              convert,
    output logic [c_NPIX-1:0] read,
    output logic [DW-1:0]     data_out,
    output logic              data_oe,
    input  logic [DW-1:0]     data_in,
    output logic [DW-1:0]     pix_data,
    output logic [c_IDX_W-1:0] pix_idx,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              busy,
    output logic              frame_done
);

    // One down-counter serves erase, expose and read-settle timing, so it
    // is sized for the widest of those three ranges.
    localparam int c_ERASE_W  = (ERASE_CYCLES > 1) ? $clog2(ERASE_CYCLES) : 1;
    localparam int c_SETTLE_W = (READ_SETTLE > 1) ? $clog2(READ_SETTLE) : 1;
    localparam int c_CNT_A    = (EXP_W > c_ERASE_W) ? EXP_W : c_ERASE_W;
    localparam int c_CNT_W    = (c_CNT_A > c_SETTLE_W) ? c_CNT_A : c_SETTLE_W;

    localparam logic [c_CNT_W-1:0] c_ERASE_LOAD  = c_CNT_W'(ERASE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_SETTLE_LOAD = c_CNT_W'(READ_SETTLE - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);
    localparam logic [EXP_W-1:0]   c_EXP_ONE     = EXP_W'(1);
    localparam logic [c_IDX_W-1:0] c_LAST_PIX    = c_IDX_W'(c_NPIX - 1);
    localparam logic [c_IDX_W-1:0] c_PIX_ONE     = c_IDX_W'(1);
    localparam logic [DW-1:0]      c_DATA_MAX    = '1;
    localparam logic [DW-1:0]      c_DATA_ONE    = DW'(1);
    localparam logic [c_NPIX-1:0]  c_READ_BIT0   = c_NPIX'(1);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_ERASE   = 3'd1;
    localparam logic [2:0] c_ST_EXPOSE  = 3'd2;
    localparam logic [2:0] c_ST_CONVERT = 3'd3;
    localparam logic [2:0] c_ST_GAP     = 3'd4;  // bus turnaround cycle
    localparam logic [2:0] c_ST_READ    = 3'd5;
    localparam logic [2:0] c_ST_WAIT    = 3'd6;
    localparam logic [2:0] c_ST_DONE    = 3'd7;

    logic [2:0]         r_state,     w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt,       w_cnt_nxt;
    logic [EXP_W-1:0]   r_exp,       w_exp_nxt;
    logic [c_IDX_W-1:0] r_pix,       w_pix_nxt;
    logic               w_launch;

    logic               r_erase,     w_erase_nxt;
    logic               r_expose,    w_expose_nxt;
    logic               r_convert,   w_convert_nxt;
    logic [c_NPIX-1:0]  r_read,      w_read_nxt;
    logic [DW-1:0]      r_data_out,  w_data_out_nxt;
    logic               r_data_oe,   w_data_oe_nxt;
    logic [DW-1:0]      r_pix_data,  w_pix_data_nxt;
    logic [c_IDX_W-1:0] r_pix_idx,   w_pix_idx_nxt;
    logic               r_pix_valid, w_pix_valid_nxt;
    logic               r_busy,      w_busy_nxt;
    logic               r_frame_done, w_frame_done_nxt;

    // State, counters and all outputs are registered together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= '0;
            r_exp        <= '0;
            r_pix        <= '0;
            r_erase      <= 1'b0;
            r_expose     <= 1'b0;
            r_convert    <= 1'b0;
            r_read       <= '0;
            r_data_out   <= '0;
            r_data_oe    <= 1'b0;
            r_pix_data   <= '0;
            r_pix_idx    <= '0;
            r_pix_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_exp        <= w_exp_nxt;
            r_pix        <= w_pix_nxt;
            r_erase      <= w_erase_nxt;
            r_expose     <= w_expose_nxt;
            r_convert    <= w_convert_nxt;
            r_read       <= w_read_nxt;
            r_data_out   <= w_data_out_nxt;
            r_data_oe    <= w_data_oe_nxt;
            r_pix_data   <= w_pix_data_nxt;
            r_pix_idx    <= w_pix_idx_nxt;
            r_pix_valid  <= w_pix_valid_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    // Next-state, phase counter, exposure latch and pixel index.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_exp_nxt   = r_exp;
        w_pix_nxt   = r_pix;
        w_launch    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start) w_launch = 1'b1;
            end
            c_ST_ERASE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = c_ST_EXPOSE;
                    w_cnt_nxt   = c_CNT_W'(r_exp - c_EXP_ONE);
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            c_ST_EXPOSE: begin
                if (r_cnt == '0) w_state_nxt = c_ST_CONVERT;
                else             w_cnt_nxt   = r_cnt - c_CNT_ONE;
            end
            c_ST_CONVERT: begin
                if (r_data_out == c_DATA_MAX) w_state_nxt = c_ST_GAP;
            end
            c_ST_GAP: begin
                w_state_nxt = c_ST_READ;
                w_cnt_nxt   = c_SETTLE_LOAD;
                w_pix_nxt   = '0;
            end
            c_ST_READ: begin
                if (r_cnt == '0) w_state_nxt = c_ST_WAIT;
                else             w_cnt_nxt   = r_cnt - c_CNT_ONE;
            end
            c_ST_WAIT: begin
                if (pix_ready) begin
                    if (r_pix == c_LAST_PIX) begin
                        w_state_nxt = c_ST_DONE;
                    end else begin
                        w_state_nxt = c_ST_READ;
                        w_cnt_nxt   = c_SETTLE_LOAD;
                        w_pix_nxt   = r_pix + c_PIX_ONE;
                    end
                end
            end
            c_ST_DONE: begin
                w_state_nxt = c_ST_IDLE;
`ifdef CONTINUOUS_FRAMES_EN
                if (start) w_launch = 1'b1;
`endif
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
        // A zero exposure request still exposes for one cycle.
        if (w_launch) begin
            w_state_nxt = c_ST_ERASE;
            w_cnt_nxt   = c_ERASE_LOAD;
            w_exp_nxt   = (expose_time == '0) ? c_EXP_ONE : expose_time;
        end
    end

    // Output values for the coming cycle, decoded from the next state.
    always_comb begin
        w_erase_nxt      = (w_state_nxt == c_ST_ERASE);
        w_expose_nxt     = (w_state_nxt == c_ST_EXPOSE);
        w_convert_nxt    = (w_state_nxt == c_ST_CONVERT);
        w_data_oe_nxt    = (w_state_nxt == c_ST_CONVERT);
        w_busy_nxt       = (w_state_nxt != c_ST_IDLE);
        w_frame_done_nxt = (w_state_nxt == c_ST_DONE);
        w_data_out_nxt   = '0;
        if (w_state_nxt == c_ST_CONVERT && r_state == c_ST_CONVERT)
            w_data_out_nxt = r_data_out + c_DATA_ONE;
        w_read_nxt = '0;
        if (w_state_nxt == c_ST_READ)
            w_read_nxt = c_READ_BIT0 << w_pix_nxt;
        w_pix_data_nxt  = r_pix_data;
        w_pix_idx_nxt   = r_pix_idx;
        w_pix_valid_nxt = r_pix_valid;
        if (r_state == c_ST_READ && r_cnt == '0) begin
            w_pix_data_nxt  = data_in;
            w_pix_idx_nxt   = r_pix;
            w_pix_valid_nxt = 1'b1;
        end
        if (r_state == c_ST_WAIT && pix_ready)
            w_pix_valid_nxt = 1'b0;
    end

    assign erase      = r_erase;
    assign expose     = r_expose;
    assign convert    = r_convert;
    assign read       = r_read;
    assign data_out   = r_data_out;
    assign data_oe    = r_data_oe;
    assign pix_data   = r_pix_data;
    assign pix_idx    = r_pix_idx;
    assign pix_valid  = r_pix_valid;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_pixel_array_readout_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pixel_array_readout_ctrl
// Description : Directed self-checking bench for pixel_array_readout_ctrl:
//               default 2x2 instance plus a 4x4 / DW=4 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_array_readout_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, pix_ready;
    logic [7:0] expose_time;
    logic       erase, expose, convert, data_oe, pix_valid, busy, frame_done;
    logic [3:0] read;
    logic [7:0] data_out, data_in, pix_data;
    logic [1:0] pix_idx;

    logic        start4, pix_ready4;
    logic [7:0]  expose_time4;
    logic        erase4, expose4, convert4, data_oe4, pix_valid4, busy4, frame_done4;
    logic [15:0] read4;
    logic [3:0]  data_out4, data_in4, pix_data4, pix_idx4;

    int n_checks = 0;
    int n_fail   = 0;

    pixel_array_readout_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .expose_time(expose_time),
        .erase(erase), .expose(expose), .convert(convert), .read(read),
        .data_out(data_out), .data_oe(data_oe), .data_in(data_in),
        .pix_data(pix_data), .pix_idx(pix_idx), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .busy(busy), .frame_done(frame_done)
    );

    pixel_array_readout_ctrl #(.NROWS(4), .NCOLS(4), .DW(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .expose_time(expose_time4),
        .erase(erase4), .expose(expose4), .convert(convert4), .read(read4),
        .data_out(data_out4), .data_oe(data_oe4), .data_in(data_in4),
        .pix_data(pix_data4), .pix_idx(pix_idx4), .pix_valid(pix_valid4),
        .pix_ready(pix_ready4), .busy(busy4), .frame_done(frame_done4)
    );

    // Pixel models: 2x2 pixel k reads 0x10+k, 4x4 pixel k reads 15-k.
    always_comb begin
        data_in = 8'h00;
        for (int k = 0; k < 4; k++) if (read[k]) data_in = 8'(16 + k);
    end
    always_comb begin
        data_in4 = 4'h0;
        for (int k = 0; k < 16; k++) if (read4[k]) data_in4 = 4'(15 - k);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Start a frame on the 2x2 instance; returns in the first ERASE cycle.
    task automatic launch(input logic [7:0] et);
        expose_time = et;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        expose_time = 8'hAA;
    endtask

    // Walk one full 2x2 frame cycle by cycle from its first ERASE cycle.
    task automatic walk_frame(input int exp_cycles, input int stall_k,
                              input int stall_n, input bit poke_start);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({erase, expose, convert, data_oe, busy} !== 5'b10001 || read !== 4'b0) begin
                n_fail++;
                $display("FAIL erase_phase cyc %0d: got e/x/c/oe/busy=%b%b%b%b%b read=%b, want 10001 0000",
                         i, erase, expose, convert, data_oe, busy, read);
            end
            @(negedge clk);
        end
        for (int i = 0; i < exp_cycles; i++) begin
            n_checks++;
            if ({erase, expose, convert, data_oe, busy} !== 5'b01001 || read !== 4'b0) begin
                n_fail++;
                $display("FAIL expose_phase cyc %0d: got e/x/c/oe/busy=%b%b%b%b%b, want 01001",
                         i, erase, expose, convert, data_oe, busy);
            end
            @(negedge clk);
        end
        for (int i = 0; i < 256; i++) begin
            if (poke_start && i == 100) start = 1'b1;
            if (poke_start && i == 102) start = 1'b0;
            n_checks++;
            if ({erase, expose, convert, data_oe, busy} !== 5'b00111 || read !== 4'b0 ||
                data_out !== 8'(i)) begin
                n_fail++;
                $display("FAIL convert_phase cyc %0d: got e/x/c/oe/busy=%b%b%b%b%b data_out=%0d, want 00111 data_out=%0d",
                         i, erase, expose, convert, data_oe, busy, data_out, i);
            end
            @(negedge clk);
        end
        n_checks++;
        if (convert !== 1'b0 || data_oe !== 1'b0 || read !== 4'b0 || data_out !== 8'h00 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL bus_gap: got convert=%b oe=%b read=%b data_out=%h busy=%b, want 0 0 0000 00 1",
                     convert, data_oe, read, data_out, busy);
        end
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            int wn;
            wn = (k == stall_k) ? stall_n : 0;
            for (int s = 0; s < 2; s++) begin
                n_checks++;
                if (read !== (4'b0001 << k) || data_oe !== 1'b0 || pix_valid !== 1'b0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL read_select pix %0d cyc %0d: got read=%b oe=%b valid=%b busy=%b, want read=%b 0 0 1",
                             k, s, read, data_oe, pix_valid, busy, 4'b0001 << k);
                end
                if (s == 1 && wn > 0) pix_ready = 1'b0;
                @(negedge clk);
            end
            for (int w = 0; w <= wn; w++) begin
                n_checks++;
                if (pix_valid !== 1'b1 || pix_data !== 8'(16 + k) || pix_idx !== 2'(k) ||
                    read !== 4'b0 || data_oe !== 1'b0) begin
                    n_fail++;
                    $display("FAIL pix_out pix %0d wait %0d: got valid=%b data=%h idx=%0d read=%b, want 1 %h %0d 0000",
                             k, w, pix_valid, pix_data, pix_idx, read, 8'(16 + k), k);
                end
                if (w == wn) pix_ready = 1'b1;
                @(negedge clk);
            end
        end
        n_checks++;
        if (frame_done !== 1'b1 || busy !== 1'b1 || pix_valid !== 1'b0 || read !== 4'b0) begin
            n_fail++;
            $display("FAIL done_pulse: got frame_done=%b busy=%b valid=%b read=%b, want 1 1 0 0000",
                     frame_done, busy, pix_valid, read);
        end
        @(negedge clk);
        n_checks++;
        if (frame_done !== 1'b0 || busy !== 1'b0 || {erase, expose, convert, data_oe} !== 4'b0) begin
            n_fail++;
            $display("FAIL idle_after: got frame_done=%b busy=%b e/x/c/oe=%b%b%b%b, want 0 0 0000",
                     frame_done, busy, erase, expose, convert, data_oe);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({erase, expose, convert, data_oe, pix_valid, busy, frame_done} !== 7'b0 ||
            read !== 4'b0 || data_out !== 8'h00 || pix_data !== 8'h00 || pix_idx !== 2'b0) begin
            n_fail++;
            $display("FAIL reset_state: got e/x/c/oe/v/busy/fd=%b%b%b%b%b%b%b read=%b data_out=%h, want all 0",
                     erase, expose, convert, data_oe, pix_valid, busy, frame_done, read, data_out);
        end
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || erase !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold: got busy=%b erase=%b, want 0 0", busy, erase);
        end
    endtask

    task automatic test_basic_frame;
        launch(8'd3);
        walk_frame(3, -1, 0, 1'b0);
    endtask

    task automatic test_backpressure;
        launch(8'd3);
        walk_frame(3, 1, 10, 1'b0);
    endtask

    task automatic test_expose_zero;
        launch(8'd0);
        walk_frame(1, -1, 0, 1'b0);
    endtask

    task automatic test_start_while_busy;
        launch(8'd2);
        walk_frame(2, -1, 0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0 || frame_done !== 1'b0 || erase !== 1'b0) begin
                n_fail++;
                $display("FAIL no_queued_frame cyc %0d: got busy=%b fd=%b erase=%b, want 0 0 0",
                         i, busy, frame_done, erase);
            end
        end
    endtask

    task automatic test_reset_mid_convert;
        bit found;
        found = 1'b0;
        launch(8'd3);
        for (int i = 0; i < 600 && !found; i++) begin
            if (convert === 1'b1 && data_out === 8'h80) found = 1'b1;
            else @(negedge clk);
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL reach_convert_80: got no data_out=80 within budget, want reached");
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        n_checks++;
        if ({erase, expose, convert, data_oe, pix_valid, busy, frame_done} !== 7'b0 ||
            read !== 4'b0 || data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL midframe_reset: got e/x/c/oe/v/busy/fd=%b%b%b%b%b%b%b data_out=%h, want all 0",
                     erase, expose, convert, data_oe, pix_valid, busy, frame_done, data_out);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0 || frame_done !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_idle cyc %0d: got busy=%b fd=%b, want 0 0", i, busy, frame_done);
            end
        end
        launch(8'd4);
        walk_frame(4, -1, 0, 1'b0);
    endtask

    task automatic test_config_4x4;
        bit found;
        found = 1'b0;
        expose_time4 = 8'd1;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (convert4 === 1'b1) found = 1'b1;
            else @(negedge clk);
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL cfg4_reach_convert: got no convert within budget, want reached");
        end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (convert4 !== 1'b1 || data_oe4 !== 1'b1 || data_out4 !== 4'(i)) begin
                n_fail++;
                $display("FAIL cfg4_convert cyc %0d: got c/oe=%b%b data_out=%0d, want 11 %0d",
                         i, convert4, data_oe4, data_out4, i);
            end
            @(negedge clk);
        end
        n_checks++;
        if (data_oe4 !== 1'b0 || read4 !== 16'b0 || convert4 !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg4_gap: got oe=%b read=%h convert=%b, want 0 0000 0", data_oe4, read4, convert4);
        end
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            for (int s = 0; s < 2; s++) begin
                n_checks++;
                if (read4 !== (16'h0001 << k)) begin
                    n_fail++;
                    $display("FAIL cfg4_read pix %0d: got read=%h, want %h", k, read4, 16'h0001 << k);
                end
                @(negedge clk);
            end
            n_checks++;
            if (pix_valid4 !== 1'b1 || pix_data4 !== 4'(15 - k) || pix_idx4 !== 4'(k)) begin
                n_fail++;
                $display("FAIL cfg4_pix pix %0d: got valid=%b data=%h idx=%0d, want 1 %h %0d",
                         k, pix_valid4, pix_data4, pix_idx4, 4'(15 - k), k);
            end
            @(negedge clk);
        end
        n_checks++;
        if (frame_done4 !== 1'b1) begin
            n_fail++;
            $display("FAIL cfg4_done: got frame_done=%b, want 1", frame_done4);
        end
        @(negedge clk);
        n_checks++;
        if (busy4 !== 1'b0 || frame_done4 !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg4_idle: got busy=%b fd=%b, want 0 0", busy4, frame_done4);
        end
    endtask

`ifdef CONTINUOUS_FRAMES_EN
    task automatic test_continuous;
        int nd, gaps;
        nd = 0;
        gaps = 0;
        expose_time = 8'd2;
        start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2000 && nd < 2; i++) begin
            if (frame_done === 1'b1) nd++;
            else if (nd == 1) start = 1'b0;
            if (busy !== 1'b1) gaps++;
            @(negedge clk);
        end
        start = 1'b0;
        n_checks++;
        if (nd != 2 || gaps != 0) begin
            n_fail++;
            $display("FAIL continuous_frames: got done_pulses=%0d busy_low_cycles=%0d, want 2 0", nd, gaps);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL continuous_stop: got busy=%b, want 0", busy);
        end
    endtask
`endif

    initial begin
        reset        = 1'b0;
        start        = 1'b0;
        pix_ready    = 1'b1;
        expose_time  = 8'd3;
        start4       = 1'b0;
        pix_ready4   = 1'b1;
        expose_time4 = 8'd1;
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_expose_zero();
        test_start_while_busy();
        test_reset_mid_convert();
        test_config_4x4();
`ifdef CONTINUOUS_FRAMES_EN
        test_continuous();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
